// File: rtl/traffic_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_pkg                                                          |
// | Shared lamp encodings, controller state enum and a clog2 helper.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package traffic_pkg;

    typedef enum logic [1:0] {
        LIGHT_RED    = 2'b00,
        LIGHT_YELLOW = 2'b01,
        LIGHT_GREEN  = 2'b10
    } light_e;

    typedef enum logic [2:0] {
        ST_GREEN       = 3'd0,
        ST_YELLOW      = 3'd1,
        ST_ALL_RED     = 3'd2,
        ST_PRE_YELLOW  = 3'd3,
        ST_PRE_ALL_RED = 3'd4,
        ST_PRE_HOLD    = 3'd5
    } state_e;

    // Never returns less than 1 so a phase index always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_phase_controller_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_phase_controller_if                                          |
// | Detector/button inputs and lamp-driver outputs of the controller.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface traffic_phase_controller_if
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES = 4
);
    localparam int PW = clog2(NUM_PHASES);

    logic                    tick;
    logic [NUM_PHASES-1:0]   veh_det;
    logic [NUM_PHASES-1:0]   ped_req;
    logic                    emergency;
    logic [PW-1:0]           emergency_phase;
    logic [2*NUM_PHASES-1:0] light;
    logic [NUM_PHASES-1:0]   walk;
    logic [PW-1:0]           active_phase;
    logic                    preempt_active;

    modport master (
        output tick, veh_det, ped_req, emergency, emergency_phase,
        input  light, walk, active_phase, preempt_active
    );

    modport slave (
        input  tick, veh_det, ped_req, emergency, emergency_phase,
        output light, walk, active_phase, preempt_active
    );
endinterface
`default_nettype wire

// File: rtl/traffic_phase_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_phase_arbiter                                                |
// | Round-robin next-phase select starting after the active phase.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module traffic_phase_arbiter
    import traffic_pkg::*;
#(
    parameter  int NUM_PHASES = 4,
    localparam int PW         = clog2(NUM_PHASES)
) (
    input  wire logic [NUM_PHASES-1:0] i_demand,
    input  wire logic [PW-1:0]         i_active_phase,
    output logic      [PW-1:0]         o_next_phase,
    output logic                       o_has_demand
);
    int            w_idx;
    logic [PW-1:0] w_sel;

    // Scan farthest-first so the nearest demanding phase is written last.
    always_comb begin
        o_next_phase = i_active_phase;
        o_has_demand = 1'b0;
        w_idx        = 0;
        w_sel        = '0;
        for (int i = NUM_PHASES - 1; i >= 1; i--) begin
            w_idx = int'(i_active_phase) + i;
            if (w_idx >= NUM_PHASES) w_idx = w_idx - NUM_PHASES;
            w_sel = PW'(w_idx);
            if (i_demand[w_sel]) begin
                o_next_phase = w_sel;
                o_has_demand = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | traffic_phase_controller                                             |
// | Actuated multi-phase signal sequencer with walk and pre-emption.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int NUM_PHASES    = 4,
    parameter int TIMER_W       = 8,
    parameter int GREEN_MIN     = 4,
    parameter int GREEN_MAX     = 16,
    parameter int EXT_TIME      = 2,
    parameter int YELLOW_TIME   = 2,
    parameter int ALL_RED_TIME  = 1,
    parameter int WALK_TIME     = 3,
    parameter int EMERGENCY_MIN = 4
) (
    input wire logic clk,
    input wire logic reset,
    traffic_phase_controller_if.slave bus
);
    localparam int PW = clog2(NUM_PHASES);
    localparam int C_MIN_PED_I = (WALK_TIME > GREEN_MIN) ? WALK_TIME : GREEN_MIN;

    localparam logic [TIMER_W-1:0] C_GMIN    = TIMER_W'(GREEN_MIN);
    localparam logic [TIMER_W-1:0] C_MIN_PED = TIMER_W'(C_MIN_PED_I);
    localparam logic [TIMER_W-1:0] C_GMAX_M1 = TIMER_W'(GREEN_MAX - 1);
    localparam logic [TIMER_W-1:0] C_EXT     = TIMER_W'(EXT_TIME);
    localparam logic [TIMER_W-1:0] C_YEL     = TIMER_W'(YELLOW_TIME);
    localparam logic [TIMER_W-1:0] C_AR      = TIMER_W'(ALL_RED_TIME);
    localparam logic [TIMER_W-1:0] C_WALK    = TIMER_W'(WALK_TIME);
    localparam logic [TIMER_W-1:0] C_EMIN    = TIMER_W'(EMERGENCY_MIN);
    localparam logic [TIMER_W-1:0] C_ONE     = TIMER_W'(1);
    localparam logic [2*NUM_PHASES-1:0] C_LIGHT_RST = {{(2*NUM_PHASES-2){1'b0}}, 2'b10};

    state_e                  state_q, state_d;
    logic [PW-1:0]           active_q, active_d;
    logic [TIMER_W-1:0]      cnt_q, cnt_d;
    logic [TIMER_W-1:0]      gap_q, gap_d;
    logic [NUM_PHASES-1:0]   demand_q, demand_d;
    logic [NUM_PHASES-1:0]   ped_dem_q, ped_dem_d;
    logic                    ped_serve_q, ped_serve_d;
    logic                    pre_q, pre_d;
    logic [PW-1:0]           epha_q, epha_d;
    logic [2*NUM_PHASES-1:0] light_q, light_d;
    logic [NUM_PHASES-1:0]   walk_q, walk_d;
    logic                    preempt_q, preempt_d;

    logic [TIMER_W-1:0] w_cnt_inc;
    logic [TIMER_W-1:0] w_min_t;
    logic               w_veh_act;
    logic               w_emer_now;
    logic [PW-1:0]      w_epha;
    logic [PW-1:0]      w_next;
    logic               w_has_demand;
    logic               w_green_end;
    logic               w_green_entry;

    traffic_phase_arbiter #(
        .NUM_PHASES (NUM_PHASES)
    ) u_arb (
        .i_demand       (demand_q),
        .i_active_phase (active_q),
        .o_next_phase   (w_next),
        .o_has_demand   (w_has_demand)
    );

    assign w_cnt_inc  = cnt_q + C_ONE;
    assign w_min_t    = ped_serve_q ? C_MIN_PED : C_GMIN;
    assign w_veh_act  = bus.veh_det[active_q];
    assign w_emer_now = bus.emergency | pre_q;
    assign w_epha     = pre_q ? epha_q : bus.emergency_phase;
    // Gap counter value 1 marks the final extension tick.
    assign w_green_end = bus.tick && ((cnt_q == C_GMAX_M1) ||
                         ((w_cnt_inc >= w_min_t) && !w_veh_act && (gap_q <= C_ONE)));

    always_comb begin
        state_d       = state_q;
        active_d      = active_q;
        cnt_d         = bus.tick ? w_cnt_inc : cnt_q;
        gap_d         = gap_q;
        demand_d      = demand_q | bus.veh_det | bus.ped_req;
        ped_dem_d     = ped_dem_q | bus.ped_req;
        ped_serve_d   = ped_serve_q;
        pre_d         = pre_q;
        epha_d        = epha_q;
        w_green_entry = 1'b0;

        if (bus.emergency && !pre_q) begin
            pre_d  = 1'b1;
            epha_d = bus.emergency_phase;
        end

        case (state_q)
            ST_GREEN: begin
                if (w_veh_act && (w_cnt_inc >= w_min_t)) gap_d = C_EXT;
                else if (bus.tick && (gap_q != '0))      gap_d = gap_q - C_ONE;
                if (w_emer_now) begin
                    state_d = (active_q == w_epha) ? ST_PRE_HOLD : ST_PRE_YELLOW;
                    cnt_d   = '0;
                end else if (w_green_end && w_has_demand) begin
                    state_d = ST_YELLOW;
                    cnt_d   = '0;
                end else if (cnt_q == C_GMAX_M1) begin
                    cnt_d = cnt_q;
                end
            end
            ST_YELLOW: begin
                if (bus.tick && (w_cnt_inc == C_YEL)) begin
                    state_d = w_emer_now ? ST_PRE_ALL_RED : ST_ALL_RED;
                    cnt_d   = '0;
                end
            end
            ST_ALL_RED: begin
                if (bus.tick && (w_cnt_inc == C_AR)) begin
                    cnt_d = '0;
                    if (w_emer_now) begin
                        state_d = ST_PRE_ALL_RED;
                    end else begin
                        state_d       = ST_GREEN;
                        active_d      = w_next;
                        w_green_entry = 1'b1;
                    end
                end
            end
            ST_PRE_YELLOW: begin
                if (bus.tick && (w_cnt_inc == C_YEL)) begin
                    state_d = ST_PRE_ALL_RED;
                    cnt_d   = '0;
                end
            end
            ST_PRE_ALL_RED: begin
                if (bus.tick && (w_cnt_inc == C_AR)) begin
                    state_d  = ST_PRE_HOLD;
                    active_d = w_epha;
                    cnt_d    = '0;
                end
            end
            ST_PRE_HOLD: begin
                // Hold count saturates at the minimum so a late release exits at once.
                if (cnt_q >= C_EMIN) cnt_d = cnt_q;
                if (!bus.emergency &&
                    ((cnt_q >= C_EMIN) || (bus.tick && (w_cnt_inc == C_EMIN)))) begin
                    state_d       = ST_GREEN;
                    cnt_d         = '0;
                    pre_d         = 1'b0;
                    w_green_entry = 1'b1;
                end
            end
            default: begin
                state_d  = ST_GREEN;
                active_d = '0;
                cnt_d    = '0;
            end
        endcase

        if (w_green_entry) begin
            demand_d[active_d]  = 1'b0;
            ped_dem_d[active_d] = 1'b0;
            ped_serve_d         = ped_dem_q[active_d];
            gap_d               = '0;
        end
    end

    always_comb begin
        light_d = '0;
        walk_d  = '0;
        case (state_d)
            ST_GREEN, ST_PRE_HOLD:     light_d[{active_d, 1'b0} +: 2] = LIGHT_GREEN;
            ST_YELLOW, ST_PRE_YELLOW:  light_d[{active_d, 1'b0} +: 2] = LIGHT_YELLOW;
            default:                   light_d = '0;
        endcase
        walk_d[active_d] = (state_d == ST_GREEN) && ped_serve_d && (cnt_d < C_WALK);
        preempt_d = (state_d == ST_PRE_YELLOW) || (state_d == ST_PRE_ALL_RED) ||
                    (state_d == ST_PRE_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_GREEN;
            active_q    <= '0;
            cnt_q       <= '0;
            gap_q       <= '0;
            demand_q    <= '0;
            ped_dem_q   <= '0;
            ped_serve_q <= 1'b0;
            pre_q       <= 1'b0;
            epha_q      <= '0;
            light_q     <= C_LIGHT_RST;
            walk_q      <= '0;
            preempt_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            active_q    <= active_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            demand_q    <= demand_d;
            ped_dem_q   <= ped_dem_d;
            ped_serve_q <= ped_serve_d;
            pre_q       <= pre_d;
            epha_q      <= epha_d;
            light_q     <= light_d;
            walk_q      <= walk_d;
            preempt_q   <= preempt_d;
        end
    end

    assign bus.light          = light_q;
    assign bus.walk           = walk_q;
    assign bus.active_phase   = active_q;
    assign bus.preempt_active = preempt_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_traffic_phase_controller                                          |
// | Directed scenarios; per-cycle expected lamp states from a queue.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_traffic_phase_controller;
    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] Y = 2'b01;
    localparam logic [1:0] G = 2'b10;

    typedef struct {
        logic [7:0] light;
        logic [3:0] walk;
        logic [1:0] act;
        logic       pre;
        string      tag;
    } exp_t;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   cyc;
    bit   div3;
    exp_t exp_q[$];

    traffic_phase_controller_if #(.NUM_PHASES(4)) bus ();

    traffic_phase_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_seg(input string tag, input int ph, input logic [1:0] col,
                            input bit walk_on, input bit pre, input int n);
        exp_t e;
        e.light = {6'b0, col} << (2 * ph);
        e.walk  = walk_on ? (4'b0001 << ph) : 4'b0000;
        e.act   = 2'(ph);
        e.pre   = pre;
        e.tag   = tag;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic next_tick();
        bus.tick = !div3 || ((cyc % 3) == 2);
        cyc++;
    endtask

    task automatic compare_one();
        exp_t        e;
        logic [14:0] obs;
        logic [14:0] expv;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL scoreboard_empty: got sample with no expectation queued, required a queued expectation");
        end else begin
            e    = exp_q.pop_front();
            obs  = {bus.light, bus.walk, bus.active_phase, bus.preempt_active};
            expv = {e.light, e.walk, e.act, e.pre};
            assert (obs === expv) n_pass++;
            else $error("FAIL %s @%0t: got light=%b walk=%b act=%0d pre=%b, required light=%b walk=%b act=%0d pre=%b",
                        e.tag, $time, bus.light, bus.walk, bus.active_phase, bus.preempt_active,
                        e.light, e.walk, e.act, e.pre);
        end
    endtask

    task automatic check_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            compare_one();
            next_tick();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset               = 1'b1;
        bus.tick            = 1'b1;
        bus.veh_det         = '0;
        bus.ped_req         = '0;
        bus.emergency       = 1'b0;
        bus.emergency_phase = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_seg("reset_state", 0, G, 0, 0, 1);
        compare_one();
        cyc = 0;
        next_tick();
    endtask

    // Safety: at most one non-Red phase, walk only on a Green phase.
    always @(negedge clk) begin
        int   nonred;
        logic ok;
        nonred = 0;
        ok     = 1'b1;
        for (int p = 0; p < 4; p++) begin
            if (bus.light[2*p +: 2] != 2'b00) nonred++;
            if (bus.walk[p] && (bus.light[2*p +: 2] != 2'b10)) ok = 1'b0;
        end
        n_total++;
        assert ((nonred <= 1) && ok) n_pass++;
        else $error("FAIL invariant @%0t: got %0d non-red, light=%b walk=%b, required <=1 non-red and walk only on green",
                    $time, nonred, bus.light, bus.walk);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        cyc     = 0;
        div3    = 1'b0;
        reset   = 1'b1;
        bus.tick            = 1'b1;
        bus.veh_det         = '0;
        bus.ped_req         = '0;
        bus.emergency       = 1'b0;
        bus.emergency_phase = '0;

        // Actuation: phase 0 extended to max by held detector, then phase 1.
        do_reset();
        bus.veh_det = 4'b0011;
        push_seg("act_g0", 0, G, 0, 0, 1);
        check_cycles(1);
        bus.veh_det = 4'b0001;
        push_seg("act_g0", 0, G, 0, 0, 14);
        push_seg("act_y0", 0, Y, 0, 0, 2);
        push_seg("act_ar0", 0, R, 0, 0, 1);
        push_seg("act_g1", 1, G, 0, 0, 4);
        push_seg("act_y1", 1, Y, 0, 0, 2);
        push_seg("act_ar1", 1, R, 0, 0, 1);
        push_seg("act_g0b", 0, G, 0, 0, 2);
        check_cycles(26);

        // Skip: demand on 0 and 2 only.
        do_reset();
        bus.veh_det = 4'b0101;
        push_seg("skip_g0", 0, G, 0, 0, 1);
        check_cycles(1);
        bus.veh_det = 4'b0000;
        push_seg("skip_g0", 0, G, 0, 0, 2);
        push_seg("skip_y0", 0, Y, 0, 0, 2);
        push_seg("skip_ar0", 0, R, 0, 0, 1);
        push_seg("skip_g2", 2, G, 0, 0, 4);
        push_seg("skip_y2", 2, Y, 0, 0, 2);
        push_seg("skip_ar2", 2, R, 0, 0, 1);
        push_seg("skip_g0b", 0, G, 0, 0, 2);
        check_cycles(14);

        // Rest: no demand at all.
        do_reset();
        push_seg("rest_g0", 0, G, 0, 0, 25);
        check_cycles(25);

        // Pedestrian on phase 1.
        do_reset();
        bus.ped_req = 4'b0010;
        push_seg("ped_g0", 0, G, 0, 0, 1);
        check_cycles(1);
        bus.ped_req = 4'b0000;
        push_seg("ped_g0", 0, G, 0, 0, 2);
        push_seg("ped_y0", 0, Y, 0, 0, 2);
        push_seg("ped_ar0", 0, R, 0, 0, 1);
        push_seg("ped_walk1", 1, G, 1, 0, 3);
        push_seg("ped_g1", 1, G, 0, 0, 6);
        check_cycles(14);

        // Pre-emption toward phase 3 from phase 0 Green.
        do_reset();
        push_seg("pre_g0", 0, G, 0, 0, 1);
        check_cycles(1);
        bus.emergency       = 1'b1;
        bus.emergency_phase = 2'd3;
        push_seg("pre_y0", 0, Y, 0, 1, 2);
        push_seg("pre_ar0", 0, R, 0, 1, 1);
        push_seg("pre_hold3", 3, G, 0, 1, 1);
        check_cycles(1);
        bus.emergency_phase = 2'd1;
        check_cycles(3);
        bus.emergency = 1'b0;
        push_seg("pre_hold3", 3, G, 0, 1, 3);
        push_seg("pre_g3", 3, G, 0, 0, 4);
        check_cycles(7);

        // Pre-emption toward the phase already Green: straight to hold.
        bus.emergency       = 1'b1;
        bus.emergency_phase = 2'd3;
        push_seg("presame_hold", 3, G, 0, 1, 1);
        check_cycles(1);
        bus.emergency = 1'b0;
        push_seg("presame_hold", 3, G, 0, 1, 3);
        push_seg("presame_g3", 3, G, 0, 0, 2);
        check_cycles(5);

        // Tick every third cycle, then reset mid-Yellow.
        div3 = 1'b1;
        do_reset();
        bus.veh_det = 4'b0101;
        push_seg("div3_g0", 0, G, 0, 0, 1);
        check_cycles(1);
        bus.veh_det = 4'b0000;
        push_seg("div3_g0", 0, G, 0, 0, 10);
        push_seg("div3_y0", 0, Y, 0, 0, 6);
        push_seg("div3_ar0", 0, R, 0, 0, 3);
        push_seg("div3_g2", 2, G, 0, 0, 12);
        push_seg("div3_y2", 2, Y, 0, 0, 3);
        check_cycles(34);
        reset = 1'b1;
        push_seg("midreset", 0, G, 0, 0, 1);
        check_cycles(1);
        reset    = 1'b0;
        div3     = 1'b0;
        bus.tick = 1'b1;
        push_seg("post_reset_rest", 0, G, 0, 0, 8);
        check_cycles(8);

        n_total++;
        assert (exp_q.size() == 0) n_pass++;
        else $error("FAIL scoreboard_drain: got %0d leftover expectations, required 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
